btn_debounce_pulse: RTL
=======================

// Module: btn_debounce_pulse
// PURPOSE
//  Input conditioner directly upstream of the lab sequence FSM.
//  Synchronises a raw push-button, debounces it, and emits a one-cycle X_OUT
//  pulse per accepted press; X_OUT drives the FSM X_IN.
//  Also exports the debounced level and a wrapping press counter for LEDs/7-seg.
// PARAMETERS
//  DEBOUNCE_CYCLES  4    consecutive stable synced cycles required; legal range >= 1
//  CNT_W            8    width of PRESS_CNT_OUT
// PORTS
//  CLK            input   1      system clock, all logic on posedge
//  RST            input   1      synchronous, active-high reset
//  BTN_IN         input   1      raw asynchronous button, active-high
//  X_OUT          output  1      one-cycle pulse per accepted press
//  LEVEL_OUT      output  1      debounced button level
//  PRESS_CNT_OUT  output  CNT_W  accepted-press count, wraps
// BEHAVIOUR
//  Interface:
//  - One clock, CLK.
//  - Reset RST is synchronous, active-high, sampled on posedge CLK.
//  Reset values:
//  - All outputs 0; sync flops 0; debounce counter 0; state IDLE.
//  Synchroniser:
//  - 2-flop, BTN_IN -> s1 -> s2; FSM reads s2 only.
//  - Debounce counter width is $clog2(DEBOUNCE_CYCLES+1).
//  States (2-bit):
//  - IDLE(0): s2=1 -> DEB_PRESS with cnt=0.
//  - DEB_PRESS(1): s2=0 -> IDLE with cnt=0 (glitch rejected).
//      s2=1 and cnt==N-1 -> PRESSED, X_OUT=1, LEVEL_OUT=1, PRESS_CNT++.
//      Otherwise cnt++.
//  - PRESSED(2): s2=0 -> DEB_RELEASE with cnt=0.
//  - DEB_RELEASE(3): s2=1 -> PRESSED with cnt=0 (bounce ignored).
//      s2=0 and cnt==N-1 -> IDLE, LEVEL_OUT=0.
//      Otherwise cnt++.
//  X_OUT:
//  - Registered; high exactly one cycle per IDLE->PRESSED traversal, never on release.
//  Latency (N=DEBOUNCE_CYCLES, edge 0 = first edge sampling BTN_IN=1):
//  - X_OUT and LEVEL_OUT go high after edge N+2.
//  - On release, LEVEL_OUT goes low after edge N+2 counted from the first 0 sample.
//  Counter:
//  - PRESS_CNT_OUT increments mod 2^CNT_W; 2^CNT_W-1 -> 0 with no flag.
//  Boundary cases:
//  - Pulses or gaps shorter than N synced cycles produce no output change.
//  - N=1: DEB states last exactly one cycle when s2 is stable.
//  - RST mid-debounce or mid-press: everything clears on that edge, X_OUT low next cycle.
//      A button still held after RST deasserts is treated as a new press and pulses once.
//  - RST has priority over every state transition.
// STRUCTURE
//  Shared header btn_defs.vh:
//  - State encodings ST_IDLE/ST_DEB_PRESS/ST_PRESSED/ST_DEB_RELEASE.
//  - Default DEBOUNCE_CYCLES for sim (4) and board (e.g. 500000).
//  Sub-module sync_2ff (CLK, RST, D_IN, Q_OUT):
//  - Reusable for other pad inputs; reset to 0.
//  Top holds the FSM, debounce counter and press counter.
// TESTING
//  - Reset: RST=1 2 cycles with BTN_IN=1 -> all outputs 0.
//      After release, X_OUT pulses at edge N+2 and PRESS_CNT_OUT=1.
//  - Clean press, N=4: BTN_IN=1 for 20 cycles -> one X_OUT pulse after edge 6.
//      LEVEL_OUT=1 thereafter; PRESS_CNT_OUT 0->1.
//  - Bounce: BTN_IN toggles 1,0,1,0 each cycle, then stays 1 -> no pulse during toggling.
//      Exactly one pulse 6 edges after the final rise.
//  - Release bounce: while pressed, drop BTN_IN for 2 cycles then restore.
//      LEVEL_OUT stays 1, no new X_OUT.
//  - Wrap: CNT_W=2, 5 clean presses -> PRESS_CNT_OUT 1,2,3,0,1; 5 single pulses.
//  - Mid-debounce reset: RST after 2 stable cycles -> cnt/state cleared, X_OUT never high that cycle.
//      Held button yields one pulse post-reset.

Source files
------------

// File: rtl/btn_debounce_pulse_pkg.sv
// Shared definitions for the push-button conditioner: FSM state encoding,
// the default debounce length and the debounce counter sizing rule.
package btn_debounce_pulse_pkg;

    typedef enum logic [1:0] {
        ST_IDLE        = 2'd0,
        ST_DEB_PRESS   = 2'd1,
        ST_PRESSED     = 2'd2,
        ST_DEB_RELEASE = 2'd3
    } btn_state_e;

    // Short enough to keep simulation fast; boards override it (e.g. 500000).
    localparam int DEBOUNCE_CYCLES_SIM = 4;

    function automatic int deb_cnt_w(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/btn_debounce_pulse_if.sv
// Button-side signal bundle: raw button in, conditioned pulse/level/count out.
// The master modport is the conditioner; the slave modport is its consumer.
interface btn_debounce_pulse_if #(
    parameter int CNT_W = 8
);
    logic             BTN_IN;
    logic             X_OUT;
    logic             LEVEL_OUT;
    logic [CNT_W-1:0] PRESS_CNT_OUT;

    modport master (
        input  BTN_IN,
        output X_OUT,
        output LEVEL_OUT,
        output PRESS_CNT_OUT
    );

    modport slave (
        output BTN_IN,
        input  X_OUT,
        input  LEVEL_OUT,
        input  PRESS_CNT_OUT
    );
endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for an asynchronous pad input; both flops clear to 0.
// Latency: two CLK edges; no backpressure.
module sync_2ff (
    input  logic CLK,
    input  logic RST,
    input  logic D_IN,
    output logic Q_OUT
);
    logic s1;

    always_ff @(posedge CLK) begin
        if (RST) begin
            s1    <= 1'b0;
            Q_OUT <= 1'b0;
        end else begin
            s1    <= D_IN;
            Q_OUT <= s1;
        end
    end
endmodule

// File: rtl/btn_debounce_pulse.sv
// Synchronise + debounce a push-button; one-cycle X_OUT per accepted press.
// Latency: X_OUT/LEVEL_OUT rise after edge N+2 of a stable press; no backpressure.
module btn_debounce_pulse
    import btn_debounce_pulse_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_SIM,
    parameter int CNT_W           = 8
) (
    input  logic                CLK,
    input  logic                RST,
    btn_debounce_pulse_if.master bus
);
    localparam int             DCW      = deb_cnt_w(DEBOUNCE_CYCLES);
    localparam logic [DCW-1:0] CNT_LAST = DCW'(DEBOUNCE_CYCLES - 1);

    logic             s2;
    btn_state_e       state, state_nxt;
    logic [DCW-1:0]   cnt, cnt_nxt;
    logic             x_q, x_nxt;
    logic             level_q, level_nxt;
    logic             press_inc;
    logic [CNT_W-1:0] press_cnt;

    sync_2ff u_sync (
        .CLK   (CLK),
        .RST   (RST),
        .D_IN  (bus.BTN_IN),
        .Q_OUT (s2)
    );

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        x_nxt     = 1'b0;
        level_nxt = level_q;
        press_inc = 1'b0;
        case (state)
            ST_IDLE: begin
                if (s2) begin
                    state_nxt = ST_DEB_PRESS;
                    cnt_nxt   = '0;
                end
            end
            ST_DEB_PRESS: begin
                if (!s2) begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = ST_PRESSED;
                    cnt_nxt   = '0;
                    x_nxt     = 1'b1;
                    level_nxt = 1'b1;
                    press_inc = 1'b1;
                end else begin
                    cnt_nxt = cnt + DCW'(1);
                end
            end
            ST_PRESSED: begin
                if (!s2) begin
                    state_nxt = ST_DEB_RELEASE;
                    cnt_nxt   = '0;
                end
            end
            ST_DEB_RELEASE: begin
                // A bounce back to 1 returns to PRESSED without a new pulse.
                if (s2) begin
                    state_nxt = ST_PRESSED;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                    level_nxt = 1'b0;
                end else begin
                    cnt_nxt = cnt + DCW'(1);
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            x_q       <= 1'b0;
            level_q   <= 1'b0;
            press_cnt <= '0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            x_q     <= x_nxt;
            level_q <= level_nxt;
            if (press_inc) begin
                press_cnt <= press_cnt + CNT_W'(1);
            end
        end
    end

    assign bus.X_OUT         = x_q;
    assign bus.LEVEL_OUT     = level_q;
    assign bus.PRESS_CNT_OUT = press_cnt;
endmodule
